// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte channel; grant registered, data/ready zero-latency pass-through.
// tx_ready_i backpressures only the granted requester. `UART_TX_ARB_LINE_LOCK_EN holds a grant per text line.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_BURST    = 64,
  parameter int unsigned IDLE_TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
);
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255 ||
      IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 65535) begin : g_bad_params
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] g_q, g_d, ptr_q, ptr_d;
  logic [IW-1:0] pick, g_next;
  logic          g_vld, xfer, rel;
  logic [7:0]    g_dat;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // Walk the search order backwards so the entry closest to ptr wins.
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[wrap_add(ptr_q, 32'(i))]) pick = wrap_add(ptr_q, 32'(i));
    end
  end

  assign g_next = wrap_add(g_q, 32'd1);

  assign busy_o      = (state_q == S_GRANT);
  assign grant_o     = busy_o ? (ONE_HOT0 << g_q) : '0;
  assign g_vld       = req_valid_i[g_q];
  assign g_dat       = req_data_i[8*g_q +: 8];
  assign tx_valid_o  = busy_o & g_vld;
  assign tx_data_o   = busy_o ? g_dat : 8'h00;
  assign req_ready_o = tx_ready_i ? grant_o : '0;
  assign xfer        = tx_valid_o & tx_ready_i;

`ifdef UART_TX_ARB_LINE_LOCK_EN
  logic [7:0]  burst_q, burst_d;
  logic [15:0] idle_q, idle_d;
  logic        burst_hit, idle_hit;

  // Both hits look at the count this cycle would produce.
  assign burst_hit = ({1'b0, burst_q} + 9'd1) >= 9'(MAX_BURST);
  assign idle_hit  = ({1'b0, idle_q} + 17'd1) >= 17'(IDLE_TIMEOUT);
  assign rel       = (xfer & ((g_dat == 8'h0A) | burst_hit)) | (~g_vld & idle_hit);

  always_comb begin
    burst_d = burst_q;
    idle_d  = idle_q;
    if (state_q == S_IDLE) begin
      burst_d = '0;
      idle_d  = '0;
    end else begin
      if (xfer && burst_q != 8'hFF) burst_d = burst_q + 8'd1;
      idle_d = g_vld ? 16'd0 : idle_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      burst_q <= '0;
      idle_q  <= '0;
    end else begin
      burst_q <= burst_d;
      idle_q  <= idle_d;
    end
  end
`else
  assign rel = xfer;
`endif

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|req_valid_i) begin
          state_d = S_GRANT;
          g_d     = pick;
        end
      end
      S_GRANT: begin
        if (rel) begin
          state_d = S_IDLE;
          ptr_d   = g_next;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues drive the DUT, a cycle model predicts every output,
// and predicted transfers feed a scoreboard popped by an independent monitor on each tx handshake.
module tb_uart_tx_arbiter;
  localparam int N       = 4;
  localparam int MAXB    = 4;
  localparam int IDLE_TO = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MAXB), .IDLE_TIMEOUT(IDLE_TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
    .tx_ready_i(tx_ready), .grant_o(grant), .busy_o(busy));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [7:0]  srcq[N][$];
  logic [N-1:0] hold = '0;
  logic [N-1:0] acc = '0;
  int unsigned gap_pct = 0;
  int unsigned rdy_pct = 100;
  int          exp_q[$];
  int          obs_req[$];
  int          obs_dat[$];

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      req_valid[r] = hold[r];
      req_data[8*r +: 8] = hold[r] ? srcq[r][0] : 8'h00;
    end
  endtask

  // One clock: retire accepted bytes, then decide next valids/ready just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    tx_ready = ($urandom_range(99) < rdy_pct);
    for (int r = 0; r < N; r++) begin
      if (acc[r]) begin
        void'(srcq[r].pop_front());
        hold[r] = 1'b0;
      end
      if (!hold[r] && srcq[r].size() > 0 && $urandom_range(99) >= gap_pct) hold[r] = 1'b1;
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    gap_pct = 0;
    rdy_pct = 100;
    step();
    step();
    for (int r = 0; r < N; r++) srcq[r].delete();
    hold = '0;
    drive();
    step();
    rst = 1'b0;
    obs_req.delete();
    obs_dat.delete();
  endtask

  // Reference model: owner = -1 means nobody granted.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_burst = 0;
  int m_idle  = 0;

  always @(negedge clk) begin : model
    logic [N-1:0] eg, er;
    logic         ev, xf, rl;
    logic [7:0]   ed;
    eg = '0;
    ev = 1'b0;
    ed = 8'h00;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ev = req_valid[m_owner];
      ed = req_data[8*m_owner +: 8];
    end
    er = tx_ready ? eg : '0;
    chk("grant_o", grant, eg);
    chk("busy_o", busy, m_owner >= 0);
    chk("tx_valid_o", tx_valid, ev);
    chk("tx_data_o", tx_data, ed);
    chk("req_ready_o", req_ready, er);
    xf = ev && tx_ready;
    rl = 1'b0;
    if (xf) exp_q.push_back(m_owner * 256 + ed);
    if (m_owner >= 0) begin
`ifdef UART_TX_ARB_LINE_LOCK_EN
      if (xf) m_burst = (m_burst < 255) ? m_burst + 1 : 255;
      m_idle = ev ? 0 : m_idle + 1;
      rl = (xf && (ed == 8'h0A || m_burst >= MAXB)) || (m_idle >= IDLE_TO);
`else
      rl = xf;
`endif
      if (rl) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      m_burst = 0;
      m_idle  = 0;
    end
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_burst = 0;
      m_idle  = 0;
    end
  end

  initial begin : monitor
    int ri;
    int e;
    forever begin
      @(negedge clk);
      #1;
      acc = req_ready & req_valid;
      if (tx_valid && tx_ready) begin
        ri = -1;
        for (int r = 0; r < N; r++) if (grant[r]) ri = r;
        obs_req.push_back(ri);
        obs_dat.push_back(int'(tx_data));
        chk("sb_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_requester", ri, e / 256);
          chk("sb_data", tx_data, e % 256);
        end
      end
    end
  end

  function automatic int obs_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin : stim
    int n;
    int held;
    int left;
    logic [7:0] ll_exp [6];
    ll_exp = '{8'h41, 8'h42, 8'h0A, 8'h78, 8'h79, 8'h0A};

    rst = 1'b1;
    tx_ready = 1'b1;
    req_valid = '0;
    req_data = '0;
    for (int r = 0; r < N; r++)
      for (int i = 0; i < 8; i++) srcq[r].push_back(8'(16 * r + i));
    hold = '1;
    drive();

    // Reset with every requester valid: outputs stay quiet.
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 2) rst = 1'b0;
      #6;
      chk("reset_outputs", {grant, busy, tx_valid, tx_data, req_ready}, 32'd0);
    end
    obs_req.delete();
    obs_dat.delete();
    step();
    #6;
    chk("first_grant", grant, 4'b0001);
    repeat (14) step();
    #6;
`ifndef UART_TX_ARB_LINE_LOCK_EN
    chk("rr_bytes_in_16", obs_req.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("rr_order", obs_at(obs_req, i), i % 4);
      chk("rr_data", obs_at(obs_dat, i), 16 * (i % 4) + i / 4);
    end
`else
    do_reset();
    for (int i = 0; i < 3; i++) srcq[1].push_back(ll_exp[i]);
    for (int i = 3; i < 6; i++) srcq[2].push_back(ll_exp[i]);
    repeat (16) step();
    #6;
    chk("ll_count", obs_dat.size(), 6);
    for (int i = 0; i < 6; i++) chk("ll_seq", obs_at(obs_dat, i), ll_exp[i]);

    do_reset();
    for (int i = 0; i < 10; i++) srcq[0].push_back(8'(8'h30 + i));
    srcq[3].push_back(8'h33);
    repeat (12) step();
    #6;
    for (int i = 0; i < 5; i++) chk("burst_cap_order", obs_at(obs_req, i), (i < 4) ? 0 : 3);

    do_reset();
    srcq[2].push_back(8'h41);
    n = 0;
    while (obs_dat.size() == 0 && n < 20) begin
      step();
      #6;
      n++;
    end
    chk("timeout_byte_sent", obs_dat.size(), 1);
    srcq[0].push_back(8'h77);
    held = 0;
    n = 0;
    do begin
      step();
      #6;
      n++;
      if (grant == 4'b0100) held++;
    end while (grant == 4'b0100 && n < 20);
    chk("timeout_low_cycles", held, IDLE_TO);
    chk("timeout_bubble", grant, 4'b0000);
    step();
    #6;
    chk("timeout_next_grant", grant, 4'b0001);
`endif

    // Backpressure: stalled byte stays presented, nothing accepted or released.
    do_reset();
    rdy_pct = 0;
    srcq[1].push_back(8'h55);
    step();
    step();
    #6;
    for (int c = 0; c < 20; c++) begin
      chk("backpressure_hold", {tx_valid, tx_data, req_ready, grant, busy},
          {1'b1, 8'h55, 4'b0000, 4'b0010, 1'b1});
      step();
      #6;
    end
    rdy_pct = 100;
    repeat (3) step();
    #6;
    chk("backpressure_sent", obs_at(obs_dat, 0), 8'h55);

    // Randomized traffic with gaps and stalls.
    do_reset();
    gap_pct = 30;
    rdy_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < N; r++) begin
        if (srcq[r].size() < 3 && $urandom_range(3) == 0)
          srcq[r].push_back(($urandom_range(7) == 0) ? 8'h0A : 8'($urandom));
      end
      step();
    end
    gap_pct = 0;
    rdy_pct = 100;
    n = 0;
    left = 1;
    while (left != 0 && n < 2000) begin
      step();
      n++;
      left = 0;
      for (int r = 0; r < N; r++) left += srcq[r].size();
    end
    repeat (12) step();
    #6;
    chk("drain_sources", left, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
